scarv_cop_aes_issue: RTL and testbench
======================================

Name: scarv_cop_aes_issue

Overview:
Issue/writeback stage directly upstream and downstream of the co-processor AES unit. It accepts one decoded AES instruction at a time from the co-processor decode stage through a valid/ready handshake and latches its operands. It holds the AES unit's valid and operands stable for the unit's multi-cycle sequence, captures the unit's result, and writes it into the co-processor register file (CPR) through an arbitrated write port. It also rejects malformed subclass encodings and supports a pipeline flush.

Parameters:
SUBCLASS_MASK, 16'h003F, id_subclass bits that denote legal AES operations (sub enc/encrot/dec/decrot, mix enc/dec)
AES_LAT, 4, expected cycles from aes_ivalid rise to aes_idone inclusive

Ports:
g_clk  in  1  clock
g_resetn  in  1  reset, synchronous, active-low
id_valid  in  1  decode presents an AES instruction
id_ready  out  1  stage can accept; high only in IDLE
id_subclass  in  16  one-hot AES subclass
id_rs1  in  32  CPR source 1 value
id_rs2  in  32  CPR source 2 value
id_rd  in  4  CPR destination index
id_flush  in  1  kill the in-flight instruction
aes_ivalid  out  1  valid to AES unit
aes_subclass  out  16  latched subclass
aes_rs1  out  32  latched rs1
aes_rs2  out  32  latched rs2
aes_idone  in  1  AES unit completion
aes_cpr_rd_ben  in  4  AES result byte enables
aes_cpr_rd_wdata  in  32  AES result
cpr_wen  out  1  CPR write request
cpr_waddr  out  4  CPR write index
cpr_wben  out  4  CPR write byte enables
cpr_wdata  out  32  CPR write data
cpr_wack  in  1  write port grant; write commits in the cycle wen && wack
insn_done  out  1  one-cycle retire pulse
insn_err  out  1  qualifies insn_done: illegal subclass
lat_err  out  1  sticky: an idone arrived at a cycle other than AES_LAT

Behaviour:
- States: IDLE, EXEC, WB, ERR. Reset puts the block in IDLE with all registered data cleared to 0 and lat_err=0. In reset, every output is 0 except id_ready, which is 1 because the block is in IDLE.
- IDLE: id_ready=1. On id_valid && !id_flush:
  - latch subclass, rs1, rs2 and rd;
  - legal when (id_subclass & ~SUBCLASS_MASK)==0 and exactly one bit of id_subclass is set; a legal instruction goes to EXEC, anything else goes to ERR.
  - id_valid && id_flush in the same cycle is ignored and the block stays in IDLE.
- ERR: insn_done=1 and insn_err=1 for exactly one cycle, then IDLE. No AES activity and no CPR write.
- EXEC:
  - aes_ivalid=1 every cycle; aes_subclass, aes_rs1 and aes_rs2 are held from the latches and never change while in EXEC.
  - A 3-bit counter cleared on entry counts EXEC cycles (first cycle=1).
  - On aes_idone: capture aes_cpr_rd_wdata and aes_cpr_rd_ben, and set lat_err if the counter != AES_LAT. Then go to WB, or to IDLE if flushed.
  - aes_ivalid drops in the cycle after idone, so the AES unit's 2-bit sequencer has wrapped to 0.
- Flush in EXEC does not drop aes_ivalid; the AES sequence always runs to idone so the unit stays in step. A flag records the kill, and the instruction then retires silently: no CPR write and no insn_done.
- WB:
  - cpr_wen=1, cpr_waddr=rd, cpr_wben=captured ben, cpr_wdata=captured data, held until cpr_wack.
  - On cpr_wack: insn_done=1 with insn_err=0 in that same cycle, then IDLE.
  - id_flush in WB with no wack in that cycle: drop the write, go to IDLE, no insn_done.
  - id_flush and cpr_wack in the same cycle: the write commits and insn_done is asserted, so the commit wins.
- cpr_wen, aes_ivalid and insn_done are never high outside their states.
- Throughput: minimum 1 (IDLE) + AES_LAT + 1 (WB) = 6 cycles per instruction with AES_LAT=4.
- Reset mid-operation (any state): return to IDLE next edge and drop every request. The AES unit shares g_resetn, so its sequencer also returns to 0.

Test Plan:
- Mix-enc issue (legal single bit, rs1=32'h0000D4BF, rs2=32'h5D300000, rd=3), AES model returns 32'h04E0_66CB with ben=4'hF at cycle 4, wack immediate -> aes_ivalid high exactly 4 cycles; cpr write to 3 with 32'h04E066CB, ben 4'hF; insn_done at cycle 6; lat_err=0.
- Illegal subclass 16'h0003 (two bits) and 16'h0040 (outside mask) -> ERR: insn_done=insn_err=1 for one cycle, aes_ivalid never rises, no cpr_wen.
- Write-port backpressure: cpr_wack held low 5 cycles in WB -> cpr_wen/waddr/wdata stable for all 5 cycles; id_ready=0; single insn_done on the first wack.
- Flush in EXEC cycle 2 -> aes_ivalid stays high until idone at cycle 4; no cpr_wen; no insn_done; next instruction issued afterwards gets correct AES results.
- AES model asserts idone at cycle 3 -> lat_err=1 and stays set across later instructions until reset.
- g_resetn low during WB with cpr_wen high -> next cycle cpr_wen=0, aes_ivalid=0, id_ready=1, lat_err=0.

Source files
------------

// File: rtl/scarv_cop_aes_issue_if.sv
// -----------------------------------------------------------------------------
// scarv_cop_aes_issue_if
//   Decode-to-issue handshake bundle for the co-processor AES issue stage.
//
//   id_valid     decode presents an AES instruction
//   id_ready     issue stage can accept (driven by the issue stage)
//   id_subclass  one-hot AES subclass
//   id_rs1       CPR source 1 value
//   id_rs2       CPR source 2 value
//   id_rd        CPR destination index
//   id_flush     kill the in-flight instruction
//
//   master : decode stage side
//   slave  : issue stage side
// -----------------------------------------------------------------------------
interface scarv_cop_aes_issue_if;
    logic        id_valid;
    logic        id_ready;
    logic [15:0] id_subclass;
    logic [31:0] id_rs1;
    logic [31:0] id_rs2;
    logic [3:0]  id_rd;
    logic        id_flush;

    modport master (
        output id_valid, id_subclass, id_rs1, id_rs2, id_rd, id_flush,
        input  id_ready
    );

    modport slave (
        input  id_valid, id_subclass, id_rs1, id_rs2, id_rd, id_flush,
        output id_ready
    );
endinterface

// File: rtl/scarv_cop_aes_issue.sv
// -----------------------------------------------------------------------------
// scarv_cop_aes_issue
//   Issue/writeback stage wrapped around the co-processor AES unit. Accepts one
//   decoded AES instruction at a time, holds the AES unit's inputs stable for
//   its multi-cycle sequence, captures the result and writes it to the CPR
//   through an arbitrated write port. Malformed subclasses retire with an error
//   flag; a flush kills the in-flight instruction.
//
// Ports:
//   g_clk, g_resetn       clock, synchronous active-low reset
//   idb (slave)           decode handshake: valid/ready, subclass, rs1, rs2,
//                         rd, flush
//   aes_ivalid            valid to the AES unit (high for the whole EXEC state)
//   aes_subclass/rs1/rs2  latched operands presented to the AES unit
//   aes_idone             AES unit completion
//   aes_cpr_rd_ben/wdata  AES result byte enables / data
//   cpr_wen/waddr/wben/wdata  CPR write request, held until cpr_wack
//   cpr_wack              write port grant; the write commits on wen && wack
//   insn_done             one-cycle retire pulse
//   insn_err              qualifies insn_done: illegal subclass
//   lat_err               sticky: idone arrived at a cycle other than AES_LAT
// -----------------------------------------------------------------------------
module scarv_cop_aes_issue #(
    parameter logic [15:0] SUBCLASS_MASK = 16'h003F,
    parameter int unsigned AES_LAT       = 4
) (
    input  logic                        g_clk,
    input  logic                        g_resetn,

    scarv_cop_aes_issue_if.slave        idb,

    output logic                        aes_ivalid,
    output logic [15:0]                 aes_subclass,
    output logic [31:0]                 aes_rs1,
    output logic [31:0]                 aes_rs2,
    input  logic                        aes_idone,
    input  logic [3:0]                  aes_cpr_rd_ben,
    input  logic [31:0]                 aes_cpr_rd_wdata,

    output logic                        cpr_wen,
    output logic [3:0]                  cpr_waddr,
    output logic [3:0]                  cpr_wben,
    output logic [31:0]                 cpr_wdata,
    input  logic                        cpr_wack,

    output logic                        insn_done,
    output logic                        insn_err,
    output logic                        lat_err
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_EXEC = 2'd1;
    localparam logic [1:0] S_WB   = 2'd2;
    localparam logic [1:0] S_ERR  = 2'd3;

    localparam logic [2:0] LAT3   = AES_LAT[2:0];
    localparam logic [2:0] CNT_MAX = 3'd7;

    logic [1:0]  state;
    logic [15:0] sub_q;
    logic [31:0] rs1_q;
    logic [31:0] rs2_q;
    logic [3:0]  rd_q;
    logic [31:0] res_q;
    logic [3:0]  ben_q;
    logic [2:0]  cnt_q;
    logic        killed_q;
    logic        lat_err_q;

    // Legal means: no bits outside the mask, and exactly one bit set.
    logic [15:0] sub_in;
    logic        sub_onehot;
    logic        sub_legal;

    assign sub_in     = idb.id_subclass;
    assign sub_onehot = (sub_in != 16'h0000) &&
                        ((sub_in & (sub_in - 16'd1)) == 16'h0000);
    assign sub_legal  = ((sub_in & ~SUBCLASS_MASK) == 16'h0000) && sub_onehot;

    always_ff @(posedge g_clk) begin
        // NOTE: every data register is cleared by reset, not only the state,
        // so the outputs it drives read 0 during and right after reset.
        if (!g_resetn) begin
            state     <= S_IDLE;
            sub_q     <= 16'h0000;
            rs1_q     <= 32'h0000_0000;
            rs2_q     <= 32'h0000_0000;
            rd_q      <= 4'h0;
            res_q     <= 32'h0000_0000;
            ben_q     <= 4'h0;
            cnt_q     <= 3'd0;
            killed_q  <= 1'b0;
            lat_err_q <= 1'b0;
        end else begin
            // NOTE: state is updated with non-blocking assignments so every
            // register samples pre-edge values, independent of statement order.
            case (state)
                S_IDLE: begin
                    // A flush in the same cycle as valid cancels the issue.
                    if (idb.id_valid && !idb.id_flush) begin
                        sub_q    <= idb.id_subclass;
                        rs1_q    <= idb.id_rs1;
                        rs2_q    <= idb.id_rs2;
                        rd_q     <= idb.id_rd;
                        cnt_q    <= 3'd1;
                        killed_q <= 1'b0;
                        state    <= sub_legal ? S_EXEC : S_ERR;
                    end
                end

                S_EXEC: begin
                    // The AES unit's sequencer must always run to idone, so a
                    // flush only marks the instruction as killed.
                    killed_q <= killed_q | idb.id_flush;
                    if (cnt_q != CNT_MAX) begin
                        cnt_q <= cnt_q + 3'd1;
                    end
                    if (aes_idone) begin
                        res_q <= aes_cpr_rd_wdata;
                        ben_q <= aes_cpr_rd_ben;
                        if (cnt_q != LAT3) begin
                            lat_err_q <= 1'b1;
                        end
                        state <= (killed_q || idb.id_flush) ? S_IDLE : S_WB;
                    end
                end

                S_WB: begin
                    // A grant in the same cycle as a flush commits the write.
                    if (cpr_wack || idb.id_flush) begin
                        state <= S_IDLE;
                    end
                end

                S_ERR: begin
                    state <= S_IDLE;
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    assign idb.id_ready  = (state == S_IDLE);

    assign aes_ivalid    = (state == S_EXEC);
    assign aes_subclass  = sub_q;
    assign aes_rs1       = rs1_q;
    assign aes_rs2       = rs2_q;

    assign cpr_wen       = (state == S_WB);
    assign cpr_waddr     = rd_q;
    assign cpr_wben      = ben_q;
    assign cpr_wdata     = res_q;

    assign insn_done     = (state == S_ERR) || ((state == S_WB) && cpr_wack);
    assign insn_err      = (state == S_ERR);
    assign lat_err       = lat_err_q;

endmodule

// File: tb/tb_scarv_cop_aes_issue.sv
// -----------------------------------------------------------------------------
// tb_scarv_cop_aes_issue
//   Directed bench for scarv_cop_aes_issue. Expected CPR writes are queued when
//   an instruction is issued and popped when the write port is granted.
// -----------------------------------------------------------------------------
module tb_scarv_cop_aes_issue;

    typedef struct packed {
        logic [3:0]  addr;
        logic [3:0]  ben;
        logic [31:0] data;
    } wr_t;

    logic        g_clk;
    logic        g_resetn;
    logic        aes_ivalid;
    logic [15:0] aes_subclass;
    logic [31:0] aes_rs1;
    logic [31:0] aes_rs2;
    logic        aes_idone;
    logic [3:0]  aes_cpr_rd_ben;
    logic [31:0] aes_cpr_rd_wdata;
    logic        cpr_wen;
    logic [3:0]  cpr_waddr;
    logic [3:0]  cpr_wben;
    logic [31:0] cpr_wdata;
    logic        cpr_wack;
    logic        insn_done;
    logic        insn_err;
    logic        lat_err;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    wr_t sb[$];

    scarv_cop_aes_issue_if idb ();

    scarv_cop_aes_issue dut (
        .g_clk            (g_clk),
        .g_resetn         (g_resetn),
        .idb              (idb),
        .aes_ivalid       (aes_ivalid),
        .aes_subclass     (aes_subclass),
        .aes_rs1          (aes_rs1),
        .aes_rs2          (aes_rs2),
        .aes_idone        (aes_idone),
        .aes_cpr_rd_ben   (aes_cpr_rd_ben),
        .aes_cpr_rd_wdata (aes_cpr_rd_wdata),
        .cpr_wen          (cpr_wen),
        .cpr_waddr        (cpr_waddr),
        .cpr_wben         (cpr_wben),
        .cpr_wdata        (cpr_wdata),
        .cpr_wack         (cpr_wack),
        .insn_done        (insn_done),
        .insn_err         (insn_err),
        .lat_err          (lat_err)
    );

    initial g_clk = 1'b0;
    always #5 g_clk = ~g_clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge g_clk);
        #1;
        cyc++;
    endtask

    // Presents one instruction for a single cycle; optionally queues its write.
    task automatic issue(input logic [15:0] sub, input logic [31:0] r1, input logic [31:0] r2,
                         input logic [3:0] rd, input logic push,
                         input logic [31:0] res, input logic [3:0] ben);
        wr_t e;
        check("issue_ready", idb.id_ready, 1'b1);
        idb.id_subclass = sub;
        idb.id_rs1      = r1;
        idb.id_rs2      = r2;
        idb.id_rd       = rd;
        idb.id_valid    = 1'b1;
        if (push) begin
            e.addr = rd;
            e.ben  = ben;
            e.data = res;
            sb.push_back(e);
        end
        step();
        idb.id_valid = 1'b0;
    endtask

    // Plays the AES unit: idone at EXEC cycle idone_at, optional flush pulse.
    task automatic run_aes(input int idone_at, input int flush_at,
                           input logic [31:0] res, input logic [3:0] ben,
                           input logic [15:0] esub, input logic [31:0] e1,
                           input logic [31:0] e2, output int hi);
        hi = 0;
        for (int c = 1; c <= 16; c++) begin
            if (aes_ivalid === 1'b1) hi++;
            check("exec_sub", aes_subclass, esub);
            check("exec_rs1", aes_rs1, e1);
            check("exec_rs2", aes_rs2, e2);
            check("exec_wen", cpr_wen, 1'b0);
            check("exec_done", insn_done, 1'b0);
            check("exec_ready", idb.id_ready, 1'b0);
            idb.id_flush     = (c == flush_at);
            aes_idone        = (c == idone_at);
            aes_cpr_rd_wdata = res;
            aes_cpr_rd_ben   = ben;
            step();
            idb.id_flush = 1'b0;
            aes_idone    = 1'b0;
            if (c == idone_at) break;
        end
        check("post_exec_ivalid", aes_ivalid, 1'b0);
    endtask

    // Holds off the grant for wack_delay cycles, then grants it once.
    task automatic do_wb(input int wack_delay, output int done_cyc);
        wr_t e;
        e = '0;
        done_cyc = -1;
        check("sb_nonempty", sb.size() > 0, 1'b1);
        if (sb.size() > 0) e = sb.pop_front();
        for (int c = 0; c <= wack_delay; c++) begin
            cpr_wack = (c == wack_delay);
            #1;
            check("wb_wen", cpr_wen, 1'b1);
            check("wb_waddr", cpr_waddr, e.addr);
            check("wb_wben", cpr_wben, e.ben);
            check("wb_wdata", cpr_wdata, e.data);
            check("wb_ready", idb.id_ready, 1'b0);
            check("wb_ivalid", aes_ivalid, 1'b0);
            check("wb_done", insn_done, (c == wack_delay));
            check("wb_err", insn_err, 1'b0);
            if (insn_done === 1'b1) done_cyc = cyc;
            step();
        end
        cpr_wack = 1'b0;
        #1;
        check("post_wb_wen", cpr_wen, 1'b0);
        check("post_wb_ready", idb.id_ready, 1'b1);
        check("post_wb_done", insn_done, 1'b0);
    endtask

    task automatic illegal(input logic [15:0] sub);
        issue(sub, 32'h1111_2222, 32'h3333_4444, 4'd5, 1'b0, 32'h0, 4'h0);
        check("err_done", insn_done, 1'b1);
        check("err_flag", insn_err, 1'b1);
        check("err_ivalid", aes_ivalid, 1'b0);
        check("err_wen", cpr_wen, 1'b0);
        step();
        check("err_done_1cyc", insn_done, 1'b0);
        check("err_flag_1cyc", insn_err, 1'b0);
        check("err_ivalid_after", aes_ivalid, 1'b0);
        check("err_ready_after", idb.id_ready, 1'b1);
    endtask

    initial begin
        int t0;
        int hi;
        int done_cyc;

        g_resetn         = 1'b0;
        idb.id_valid     = 1'b0;
        idb.id_subclass  = 16'h0;
        idb.id_rs1       = 32'h0;
        idb.id_rs2       = 32'h0;
        idb.id_rd        = 4'h0;
        idb.id_flush     = 1'b0;
        aes_idone        = 1'b0;
        aes_cpr_rd_ben   = 4'h0;
        aes_cpr_rd_wdata = 32'h0;
        cpr_wack         = 1'b0;
        step();
        step();

        // Reset state
        check("rst_ready", idb.id_ready, 1'b1);
        check("rst_ivalid", aes_ivalid, 1'b0);
        check("rst_sub", aes_subclass, 16'h0);
        check("rst_rs1", aes_rs1, 32'h0);
        check("rst_wen", cpr_wen, 1'b0);
        check("rst_wdata", cpr_wdata, 32'h0);
        check("rst_done", insn_done, 1'b0);
        check("rst_err", insn_err, 1'b0);
        check("rst_laterr", lat_err, 1'b0);
        g_resetn = 1'b1;
        step();

        // Mix-enc issue, nominal latency, immediate grant
        t0 = cyc;
        issue(16'h0010, 32'h0000_D4BF, 32'h5D30_0000, 4'd3, 1'b1, 32'h04E0_66CB, 4'hF);
        run_aes(4, 0, 32'h04E0_66CB, 4'hF, 16'h0010, 32'h0000_D4BF, 32'h5D30_0000, hi);
        check("t1_ivalid_cycles", hi, 4);
        do_wb(0, done_cyc);
        check("t1_done_cycle", done_cyc - t0 + 1, 6);
        check("t1_laterr", lat_err, 1'b0);

        // Illegal subclasses
        illegal(16'h0003);
        illegal(16'h0040);

        // valid together with flush in IDLE is ignored
        idb.id_subclass = 16'h0001;
        idb.id_valid    = 1'b1;
        idb.id_flush    = 1'b1;
        step();
        idb.id_valid = 1'b0;
        idb.id_flush = 1'b0;
        check("idle_flush_ready", idb.id_ready, 1'b1);
        check("idle_flush_ivalid", aes_ivalid, 1'b0);
        check("idle_flush_done", insn_done, 1'b0);

        // Write-port backpressure: grant withheld 5 cycles
        issue(16'h0001, 32'hA5A5_0001, 32'h5A5A_0002, 4'd9, 1'b1, 32'hDEAD_BEEF, 4'h6);
        run_aes(4, 0, 32'hDEAD_BEEF, 4'h6, 16'h0001, 32'hA5A5_0001, 32'h5A5A_0002, hi);
        check("bp_ivalid_cycles", hi, 4);
        do_wb(5, done_cyc);

        // Flush in EXEC cycle 2: sequence completes, retires silently
        issue(16'h0004, 32'h0BAD_0BAD, 32'h0F0F_0F0F, 4'd7, 1'b0, 32'h0, 4'h0);
        run_aes(4, 2, 32'hFFFF_FFFF, 4'hF, 16'h0004, 32'h0BAD_0BAD, 32'h0F0F_0F0F, hi);
        check("fl_ivalid_cycles", hi, 4);
        for (int k = 0; k < 2; k++) begin
            check("fl_wen", cpr_wen, 1'b0);
            check("fl_done", insn_done, 1'b0);
            check("fl_ready", idb.id_ready, 1'b1);
            step();
        end
        issue(16'h0020, 32'h1234_5678, 32'h9ABC_DEF0, 4'd12, 1'b1, 32'hCAFE_F00D, 4'h3);
        run_aes(4, 0, 32'hCAFE_F00D, 4'h3, 16'h0020, 32'h1234_5678, 32'h9ABC_DEF0, hi);
        check("fl_next_ivalid_cycles", hi, 4);
        do_wb(0, done_cyc);

        // Flush in WB without grant: write dropped, no retire
        issue(16'h0002, 32'h0000_0001, 32'h0000_0002, 4'd1, 1'b0, 32'h0, 4'h0);
        run_aes(4, 0, 32'h7777_7777, 4'hF, 16'h0002, 32'h0000_0001, 32'h0000_0002, hi);
        check("wbfl_wen", cpr_wen, 1'b1);
        idb.id_flush = 1'b1;
        #1;
        check("wbfl_done", insn_done, 1'b0);
        step();
        idb.id_flush = 1'b0;
        check("wbfl_wen_after", cpr_wen, 1'b0);
        check("wbfl_ready_after", idb.id_ready, 1'b1);
        check("wbfl_done_after", insn_done, 1'b0);

        // Flush and grant in the same WB cycle: commit wins
        issue(16'h0008, 32'h0000_00AA, 32'h0000_00BB, 4'd2, 1'b1, 32'h0102_0304, 4'hC);
        run_aes(4, 0, 32'h0102_0304, 4'hC, 16'h0008, 32'h0000_00AA, 32'h0000_00BB, hi);
        idb.id_flush = 1'b1;
        do_wb(0, done_cyc);
        idb.id_flush = 1'b0;
        check("wbfl_ack_done_seen", done_cyc >= 0, 1'b1);
        check("pre_early_laterr", lat_err, 1'b0);

        // Early idone (cycle 3): sticky latency error
        issue(16'h0010, 32'h0000_0011, 32'h0000_0022, 4'd4, 1'b1, 32'h5555_AAAA, 4'hF);
        run_aes(3, 0, 32'h5555_AAAA, 4'hF, 16'h0010, 32'h0000_0011, 32'h0000_0022, hi);
        check("early_ivalid_cycles", hi, 3);
        check("early_laterr", lat_err, 1'b1);
        do_wb(0, done_cyc);
        issue(16'h0001, 32'h0000_0033, 32'h0000_0044, 4'd6, 1'b1, 32'h6666_9999, 4'h1);
        run_aes(4, 0, 32'h6666_9999, 4'h1, 16'h0001, 32'h0000_0033, 32'h0000_0044, hi);
        do_wb(0, done_cyc);
        check("laterr_sticky", lat_err, 1'b1);

        // Reset while in WB with the write pending
        issue(16'h0020, 32'h0000_0055, 32'h0000_0066, 4'd8, 1'b1, 32'h1357_9BDF, 4'hF);
        run_aes(4, 0, 32'h1357_9BDF, 4'hF, 16'h0020, 32'h0000_0055, 32'h0000_0066, hi);
        check("rstwb_wen_before", cpr_wen, 1'b1);
        g_resetn = 1'b0;
        step();
        check("rstwb_wen", cpr_wen, 1'b0);
        check("rstwb_ivalid", aes_ivalid, 1'b0);
        check("rstwb_ready", idb.id_ready, 1'b1);
        check("rstwb_laterr", lat_err, 1'b0);
        check("rstwb_done", insn_done, 1'b0);
        sb.delete();
        g_resetn = 1'b1;
        step();

        check("sb_empty", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
